// File: rtl/lab2_pkg.sv
// rtl/lab2_pkg.sv - shared scan-state type and default timing constants
package lab2_pkg;

  localparam int CYCLES_PER_DIGIT_DEF = 24000;
  localparam int DEAD_CYCLES_DEF      = 240;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_DEAD1 = 3'd1,
    ST_SHOW1 = 3'd2,
    ST_DEAD2 = 3'd3,
    ST_SHOW2 = 3'd4
  } scan_state_t;

endpackage

// File: rtl/lab2_slot_counter.sv
// rtl/lab2_slot_counter.sv - per-state slot counter with terminal-count detect
module lab2_slot_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Count enabled cycles; a clear wins so the next state always starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Done only on an enabled cycle, so a frozen scan never completes a slot.
  assign o_done = i_en && (r_count == i_term);

endmodule

// File: rtl/lab2_disp_scan.sv
// rtl/lab2_disp_scan.sv - two-digit display scanner with dead-time blanking
module lab2_disp_scan
  import lab2_pkg::*;
#(
  parameter int CYCLES_PER_DIGIT = CYCLES_PER_DIGIT_DEF,
  parameter int DEAD_CYCLES      = DEAD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic       enabler,
  output logic       blank,
  output logic [3:0] s1_q,
  output logic [3:0] s2_q,
  output logic       frame_tick
);

  localparam int CNT_W = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
  localparam logic [CNT_W-1:0] DEAD_TERM = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SHOW_TERM = CNT_W'(CYCLES_PER_DIGIT - DEAD_CYCLES - 1);
  // With no dead time the dead states are skipped entirely.
  localparam scan_state_t FRAME_FIRST = (DEAD_CYCLES == 0) ? ST_SHOW1 : ST_DEAD1;
  localparam scan_state_t SLOT2_FIRST = (DEAD_CYCLES == 0) ? ST_SHOW2 : ST_DEAD2;

  if (CYCLES_PER_DIGIT < 2) begin : g_bad_cpd
    $error("lab2_disp_scan: CYCLES_PER_DIGIT must be at least 2");
  end
  if (DEAD_CYCLES < 0 || DEAD_CYCLES >= CYCLES_PER_DIGIT) begin : g_bad_dead
    $error("lab2_disp_scan: DEAD_CYCLES must be in 0 .. CYCLES_PER_DIGIT-1");
  end

  scan_state_t      r_state;
  logic             r_enabler;
  logic             r_blank;
  logic             r_frame_tick;
  logic [3:0]       r_s1_q;
  logic [3:0]       r_s2_q;

  scan_state_t      w_next_state;
  logic             w_frame_start;
  logic             w_enabler_nxt;
  logic             w_blank_nxt;
  logic             w_done;
  logic             w_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_term;

  assign w_term   = (r_state == ST_DEAD1 || r_state == ST_DEAD2) ? DEAD_TERM : SHOW_TERM;
  assign w_cnt_en = en && (r_state != ST_START);
  assign w_clr    = (w_next_state != r_state);

  lab2_slot_counter #(
    .W (CNT_W)
  ) u_slot_counter (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_clr),
    .i_en   (w_cnt_en),
    .i_term (w_term),
    .o_done (w_done)
  );

  // Next state plus the output values that go with it, so outputs move with the state.
  always_comb begin
    w_next_state  = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      ST_START: begin
        if (en) begin
          w_next_state  = FRAME_FIRST;
          w_frame_start = 1'b1;
        end
      end
      ST_DEAD1: if (w_done) w_next_state = ST_SHOW1;
      ST_SHOW1: if (w_done) w_next_state = SLOT2_FIRST;
      ST_DEAD2: if (w_done) w_next_state = ST_SHOW2;
      ST_SHOW2: begin
        if (w_done) begin
          w_next_state  = FRAME_FIRST;
          w_frame_start = 1'b1;
        end
      end
      default: w_next_state = ST_START;
    endcase
    w_enabler_nxt = (w_next_state == ST_DEAD2) || (w_next_state == ST_SHOW2);
    w_blank_nxt   = !en || (w_next_state == ST_START) ||
                    (w_next_state == ST_DEAD1) || (w_next_state == ST_DEAD2);
  end

  // State register; reset aborts any slot in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered outputs; digit values are latched only at frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enabler    <= 1'b0;
      r_blank      <= 1'b1;
      r_frame_tick <= 1'b0;
      r_s1_q       <= 4'h0;
      r_s2_q       <= 4'h0;
    end else begin
      r_enabler    <= w_enabler_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_s1_q <= s1;
        r_s2_q <= s2;
      end
    end
  end

  assign enabler    = r_enabler;
  assign blank      = r_blank;
  assign frame_tick = r_frame_tick;
  assign s1_q       = r_s1_q;
  assign s2_q       = r_s2_q;

endmodule

// File: doc/lab2_disp_scan.md
LAB2_DISP_SCAN -- requirements
Module: lab2_disp_scan

Interface
REQ-001 Parameter CYCLES_PER_DIGIT, default 24000, is the number of clock cycles in one digit slot (dead time plus show time).
REQ-002 Parameter DEAD_CYCLES, default 240, is the number of blanked cycles at the start of each slot.
REQ-003 clk  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; when high the scan advances, when low it freezes and the display is blanked.
REQ-006 s1  input  4  digit-1 nibble, sampled at frame start.
REQ-007 s2  input  4  digit-2 nibble, sampled at frame start.
REQ-008 enabler  output  1  digit select for the downstream display mux (0 = digit 1, 1 = digit 2).
REQ-009 blank  output  1  high forces both digit drivers off.
REQ-010 s1_q  output  4  frame-stable copy of s1.
REQ-011 s2_q  output  4  frame-stable copy of s2.
REQ-012 frame_tick  output  1  one-cycle pulse marking frame start.

Function
REQ-013 The FSM SHALL have five states: START, DEAD1, SHOW1, DEAD2, SHOW2.
REQ-014 All outputs SHALL be registered and SHALL update on the same edge as the corresponding state transition.
REQ-015 START SHALL move to DEAD1 on the first cycle with en=1.
REQ-016 DEAD1 SHALL last DEAD_CYCLES enabled cycles, then go to SHOW1.
REQ-017 SHOW1 SHALL last CYCLES_PER_DIGIT-DEAD_CYCLES enabled cycles, then go to DEAD2.
REQ-018 DEAD2 SHALL last DEAD_CYCLES enabled cycles, then go to SHOW2.
REQ-019 SHOW2 SHALL last CYCLES_PER_DIGIT-DEAD_CYCLES enabled cycles, then go to DEAD1.
REQ-020 Output decode by state:
  - enabler = 0 in START, DEAD1 and SHOW1; enabler = 1 in DEAD2 and SHOW2.
  - blank = 1 in START, DEAD1 and DEAD2, and in any cycle with en=0; blank = 0 otherwise.
REQ-021 enabler SHALL change only on entry to DEAD1 or DEAD2, so it never changes while blank=0.
REQ-022 frame_tick SHALL pulse high for exactly one cycle on each entry to DEAD1, whether from START or from SHOW2.
REQ-023 s1_q and s2_q SHALL capture s1 and s2 on the same edge that asserts frame_tick, and SHALL hold between frame ticks.
REQ-024 Frame period SHALL be exactly 2*CYCLES_PER_DIGIT enabled cycles.
REQ-025 The slot counter SHALL count 0 to len-1 within each state and clear on every state transition.
REQ-026 The slot counter width SHALL be $clog2(CYCLES_PER_DIGIT).
REQ-027 With DEAD_CYCLES=0, DEAD1 and DEAD2 SHALL be bypassed: SHOW2 goes to SHOW1, START goes to SHOW1, and frame_tick fires on SHOW1 entry from SHOW2 or START.
REQ-028 When en=0, state and counter SHALL hold, blank SHALL be 1, and frame_tick SHALL be 0. On en=1 the scan SHALL resume with the remaining count unchanged.
REQ-029 Parameter checks SHALL be made at elaboration:
  - CYCLES_PER_DIGIT >= 2;
  - DEAD_CYCLES < CYCLES_PER_DIGIT;
  - a violation is an error.

Reset
REQ-030 While reset=0, asynchronously and without a clock edge, the block SHALL hold:
  - state = START, counter = 0;
  - enabler = 0, blank = 1, frame_tick = 0;
  - s1_q = 0, s2_q = 0.
REQ-031 An assertion of reset in the middle of any state SHALL abort the frame immediately, with no partial slot completed.
REQ-032 After reset release, the first enabled edge SHALL behave exactly as REQ-015.

Structure
REQ-033 Shared package lab2_pkg SHALL hold:
  - the scan-state enum typedef;
  - default constants CYCLES_PER_DIGIT_DEF and DEAD_CYCLES_DEF.
REQ-034 One sub-module, lab2_slot_counter, SHALL implement the counter:
  - clear, enable and terminal-value inputs;
  - a done output, asserted when the count equals terminal and enable is high;
  - the FSM in lab2_disp_scan consumes done.

Verification (CYCLES_PER_DIGIT=10, DEAD_CYCLES=2)
REQ-035 Release reset; en=1, s1=3, s2=A:
  - frame_tick on the first edge, with s1_q=3 and s2_q=A;
  - blank=1 for 2 cycles, then blank=0 with enabler=0 for 8 cycles;
  - then blank=1 with enabler=1 for 2 cycles, then blank=0 for 8 cycles;
  - next frame_tick 20 cycles after the first.
REQ-036 Change s1 to 5 in SHOW1 -> s1_q stays 3 until the next frame_tick, then becomes 5.
REQ-037 Drop en for 5 cycles at SHOW1 count 4:
  - blank=1 and state frozen while en=0;
  - after resume, SHOW1 lasts 4 more cycles;
  - frame period becomes 25 cycles.
REQ-038 DEAD_CYCLES=0 -> blank=0 throughout scanning, enabler toggles every 10 cycles, frame_tick every 20 cycles.
REQ-039 Assert reset mid-SHOW2 between clock edges -> blank=1, enabler=0, s1_q=s2_q=0 before the next clock edge.
REQ-040 Run 2000 cycles with random en -> an assertion confirms enabler never changes while blank=0 and frame_tick is never high for 2 consecutive cycles.
